hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_if.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bus: pipeline hazard sources in, stage enables and perf counters out.
// The master drives the hazard sources; the slave is the stall controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic [4:0]       EX_rt;
    logic             EX_MemRead;
    logic             branch_taken;
    logic             mem_busy;
    logic             PCWrite;
    logic             IF_IDWrite;
    logic             IF_IDFlush;
    logic             ID_EXBubble;
    logic             ID_EXWrite;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output ID_rs, ID_rt, EX_rt, EX_MemRead, branch_taken, mem_busy,
        input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, ID_EXWrite,
        input  ctrl_state, stall_cycles, flush_cycles
    );

    modport slave (
        input  ID_rs, ID_rt, EX_rt, EX_MemRead, branch_taken, mem_busy,
        output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, ID_EXWrite,
        output ctrl_state, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle branch flush and memory freeze,
// with combinational stage enables and saturating stall/flush event counters.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic                Clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'((FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0);

    state_t           state_q, state_d;
    state_t           held_q, held_d;
    state_t           eff_state;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use;
    logic             stall_ev;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble, idex_we;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    assign load_use = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
                      ((bus.EX_rt == bus.ID_rs) || (bus.EX_rt == bus.ID_rt));

    // Leaving MEMWAIT resumes the frozen state in the same cycle, so decode from the held state.
    assign eff_state = (state_q == MEMWAIT) ? held_q : state_q;

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_we     = 1'b0;
        stall_ev    = 1'b0;
        state_d     = state_q;
        held_d      = held_q;
        cnt_d       = cnt_q;
        if (rst) begin
            state_d = RUN;
        end else if (bus.mem_busy) begin
            state_d  = MEMWAIT;
            stall_ev = 1'b1;
            if (state_q != MEMWAIT) held_d = state_q;
        end else begin
            case (eff_state)
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    idex_we     = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (load_use) begin
                        idex_bubble = 1'b1;
                        idex_we     = 1'b1;
                        stall_ev    = 1'b1;
                    end else if (bus.branch_taken) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        idex_we = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q <= RUN;
            held_q  <= RUN;
            cnt_q   <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            stall_q <= sat_inc(stall_q, stall_ev);
            flush_q <= sat_inc(flush_q, ifid_flush);
        end
    end

    assign bus.PCWrite      = pc_we;
    assign bus.IF_IDWrite   = ifid_we;
    assign bus.IF_IDFlush   = ifid_flush;
    assign bus.ID_EXBubble  = idex_bubble;
    assign bus.ID_EXWrite   = idex_we;
    assign bus.ctrl_state   = state_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_cycles = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven bench for hazard_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4) with an expectation queue.
module tb_hazard_stall_ctrl;
    localparam int CNT_W = 4;

    logic Clk = 1'b0;
    logic rst;

    always #5 Clk = ~Clk;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    // outs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, ID_EXWrite}
    typedef struct {
        string      name;
        logic       r;
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       mb;
        logic [4:0] outs;
        int         st;
        int         sc;
        int         fc;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] outs;
        int         st;
        int         sc;
        int         fc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [4:0] O_RUN   = 5'b11001;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_BR    = 5'b11101;
    localparam logic [4:0] O_FL    = 5'b00111;
    localparam logic [4:0] O_ZERO  = 5'b00000;

    function automatic vec_t mk(string n, logic r, logic mr, int ert, int rs, int rt,
                                logic br, logic mb, logic [4:0] o, int st, int sc, int fc);
        vec_t v;
        v.name = n; v.r = r; v.mr = mr;
        v.ert = 5'(ert); v.rs = 5'(rs); v.rt = 5'(rt);
        v.br = br; v.mb = mb; v.outs = o;
        v.st = st; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check(string n, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        logic [4:0] got;
        @(posedge Clk);
        #1;
        rst              = v.r;
        bus.EX_MemRead   = v.mr;
        bus.EX_rt        = v.ert;
        bus.ID_rs        = v.rs;
        bus.ID_rt        = v.rt;
        bus.branch_taken = v.br;
        bus.mem_busy     = v.mb;
        e.name = v.name; e.outs = v.outs; e.st = v.st; e.sc = v.sc; e.fc = v.fc;
        sb.push_back(e);
        @(negedge Clk);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 1 expected 0", v.name);
        end else begin
            e   = sb.pop_front();
            got = {bus.PCWrite, bus.IF_IDWrite, bus.IF_IDFlush, bus.ID_EXBubble, bus.ID_EXWrite};
            check({e.name, ".PCWrite"},     int'(got[4]), int'(e.outs[4]));
            check({e.name, ".IF_IDWrite"},  int'(got[3]), int'(e.outs[3]));
            check({e.name, ".IF_IDFlush"},  int'(got[2]), int'(e.outs[2]));
            check({e.name, ".ID_EXBubble"}, int'(got[1]), int'(e.outs[1]));
            check({e.name, ".ID_EXWrite"},  int'(got[0]), int'(e.outs[0]));
            check({e.name, ".ctrl_state"},  int'(bus.ctrl_state), e.st);
            check({e.name, ".stall_cycles"}, int'(bus.stall_cycles), e.sc);
            check({e.name, ".flush_cycles"}, int'(bus.flush_cycles), e.fc);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.EX_MemRead = 1'b0; bus.EX_rt = '0; bus.ID_rs = '0; bus.ID_rt = '0;
        bus.branch_taken = 1'b0; bus.mem_busy = 1'b0;
        repeat (2) @(posedge Clk);

        //                  name        r  mr ert rs rt br mb outs     st sc fc
        tbl.push_back(mk("rst_noise",   1, 1, 5, 5, 0, 1, 1, O_ZERO,  0, 0, 0));
        tbl.push_back(mk("idle0",       0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 0, 0));
        tbl.push_back(mk("lu_rs",       0, 1, 5, 5, 0, 0, 0, O_STALL, 0, 0, 0));
        tbl.push_back(mk("lu_r0",       0, 1, 0, 0, 0, 0, 0, O_RUN,   0, 1, 0));
        tbl.push_back(mk("lu_rt",       0, 1, 7, 1, 7, 0, 0, O_STALL, 0, 1, 0));
        tbl.push_back(mk("no_load",     0, 0, 7, 1, 7, 0, 0, O_RUN,   0, 2, 0));
        tbl.push_back(mk("br",          0, 0, 0, 0, 0, 1, 0, O_BR,    0, 2, 0));
        tbl.push_back(mk("fl1",         0, 0, 0, 0, 0, 0, 0, O_FL,    1, 2, 1));
        tbl.push_back(mk("fl2_ign",     0, 1, 3, 3, 0, 1, 0, O_FL,    1, 2, 2));
        tbl.push_back(mk("br_done",     0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 2, 3));
        tbl.push_back(mk("lu_and_br",   0, 1, 4, 4, 0, 1, 0, O_STALL, 0, 2, 3));
        tbl.push_back(mk("br_after_lu", 0, 0, 4, 4, 0, 1, 0, O_BR,    0, 3, 3));
        tbl.push_back(mk("fl1b",        0, 0, 0, 0, 0, 0, 0, O_FL,    1, 3, 4));
        tbl.push_back(mk("fl2b",        0, 0, 0, 0, 0, 0, 0, O_FL,    1, 3, 5));
        tbl.push_back(mk("run_b",       0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 3, 6));
        // memory freeze in the middle of a flush
        tbl.push_back(mk("rst_a",       1, 0, 0, 0, 0, 0, 0, O_ZERO,  0, 3, 6));
        tbl.push_back(mk("mw_br",       0, 0, 0, 0, 0, 1, 0, O_BR,    0, 0, 0));
        tbl.push_back(mk("mw_fl1",      0, 0, 0, 0, 0, 0, 0, O_FL,    1, 0, 1));
        tbl.push_back(mk("mw_busy1",    0, 0, 0, 0, 0, 0, 1, O_ZERO,  1, 0, 2));
        tbl.push_back(mk("mw_busy2",    0, 0, 0, 0, 0, 0, 1, O_ZERO,  2, 1, 2));
        tbl.push_back(mk("mw_busy3",    0, 0, 0, 0, 0, 0, 1, O_ZERO,  2, 2, 2));
        tbl.push_back(mk("mw_busy4",    0, 1, 2, 2, 0, 1, 1, O_ZERO,  2, 3, 2));
        tbl.push_back(mk("mw_resume",   0, 0, 0, 0, 0, 0, 0, O_FL,    2, 4, 2));
        tbl.push_back(mk("mw_run",      0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 4, 3));
        // freeze from RUN, release straight into a load-use stall
        tbl.push_back(mk("mr_busy",     0, 0, 0, 0, 0, 0, 1, O_ZERO,  0, 4, 3));
        tbl.push_back(mk("mr_lu",       0, 1, 9, 9, 0, 0, 0, O_STALL, 2, 5, 3));
        tbl.push_back(mk("mr_run",      0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 6, 3));
        // reset during MEMWAIT and during FLUSH
        tbl.push_back(mk("rm_busy1",    0, 0, 0, 0, 0, 0, 1, O_ZERO,  0, 6, 3));
        tbl.push_back(mk("rm_busy2",    0, 0, 0, 0, 0, 0, 1, O_ZERO,  2, 7, 3));
        tbl.push_back(mk("rm_rst",      1, 0, 0, 0, 0, 1, 1, O_ZERO,  2, 8, 3));
        tbl.push_back(mk("rm_after",    0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 0, 0));
        tbl.push_back(mk("rf_br",       0, 0, 0, 0, 0, 1, 0, O_BR,    0, 0, 0));
        tbl.push_back(mk("rf_rst",      1, 0, 0, 0, 0, 0, 0, O_ZERO,  1, 0, 1));
        tbl.push_back(mk("rf_after",    0, 0, 0, 0, 0, 0, 0, O_RUN,   0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // 20-cycle load-use run: the 4-bit stall counter must pin at 15
        for (int i = 0; i < 20; i++)
            apply(mk($sformatf("sat%0d", i), 0, 1, 6, 0, 6, 0, 0, O_STALL, 0,
                     (i > 15) ? 15 : i, 0));
        apply(mk("sat_end", 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 15, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
